// File: rtl/mem_initiator.sv
// Bus master for a 32x8 synchronous memory: self-test sweep (write seeded pattern,
// read back, count mismatches) and a single-access host req/rsp port.
module mem_initiator #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] seed,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W:0]   err_count,
   output logic [ADDR_W-1:0] fail_addr,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out,
   output logic              mem_write,
   output logic              mem_read
);

   typedef enum logic [2:0] {
      IDLE, SW_WR, SW_RD, SW_DRAIN, SW_DONE, H_WR, H_RD, H_CAP
   } state_t;

   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   ERR_MAX = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

   state_t            state;
   logic [ADDR_W-1:0] cnt;
   logic [DATA_W-1:0] seed_q;

   logic              cmp_en;
   logic              mismatch;
   logic [ADDR_W-1:0] cmp_addr;
   logic [ADDR_W:0]   err_next;

   function automatic logic [DATA_W-1:0] exp_word(input logic [DATA_W-1:0] s,
                                                   input logic [ADDR_W-1:0] a);
      logic [ADDR_W+DATA_W-1:0] wide;
      wide = {{DATA_W{1'b0}}, a};
      return s ^ wide[DATA_W-1:0];
   endfunction

   function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
      return (v >= ERR_MAX) ? v : v + (ADDR_W + 1)'(1);
   endfunction

   // Read data for address cnt-1 is on the bus while cnt is being issued; the
   // counter wraps to 0 in SW_DRAIN so cnt-1 lands on the last address there.
   always_comb begin
      cmp_en   = ((state == SW_RD) && (cnt != '0)) || (state == SW_DRAIN);
      cmp_addr = cnt - ONE;
      mismatch = cmp_en && (mem_data_out != exp_word(seed_q, cmp_addr));
      err_next = mismatch ? sat_inc(err_count) : err_count;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         seed_q      <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         err_count   <= '0;
         fail_addr   <= '0;
         req_ready   <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         mem_addr    <= '0;
         mem_data_in <= '0;
         mem_write   <= 1'b0;
         mem_read    <= 1'b0;
      end else begin
         done      <= 1'b0;
         rsp_valid <= 1'b0;
         if (mismatch) begin
            err_count <= err_next;
            if (err_count == '0)
               fail_addr <= cmp_addr;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state       <= SW_WR;
                  busy        <= 1'b1;
                  req_ready   <= 1'b0;
                  err_count   <= '0;
                  fail_addr   <= '0;
                  pass        <= 1'b0;
                  seed_q      <= seed;
                  cnt         <= '0;
                  mem_write   <= 1'b1;
                  mem_addr    <= '0;
                  mem_data_in <= exp_word(seed, '0);
               end else if (req_valid && req_ready) begin
                  busy      <= 1'b1;
                  req_ready <= 1'b0;
                  mem_addr  <= req_addr;
                  if (req_write) begin
                     state       <= H_WR;
                     mem_write   <= 1'b1;
                     mem_data_in <= req_wdata;
                  end else begin
                     state    <= H_RD;
                     mem_read <= 1'b1;
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            SW_WR: begin
               if (cnt == LAST) begin
                  state     <= SW_RD;
                  mem_write <= 1'b0;
                  mem_read  <= 1'b1;
                  cnt       <= '0;
                  mem_addr  <= '0;
               end else begin
                  cnt         <= cnt + ONE;
                  mem_addr    <= cnt + ONE;
                  mem_data_in <= exp_word(seed_q, cnt + ONE);
               end
            end
            SW_RD: begin
               cnt <= cnt + ONE;
               if (cnt == LAST) begin
                  state    <= SW_DRAIN;
                  mem_read <= 1'b0;
               end else begin
                  mem_addr <= cnt + ONE;
               end
            end
            SW_DRAIN: begin
               state <= SW_DONE;
               done  <= 1'b1;
               pass  <= (err_next == '0);
            end
            SW_DONE: begin
               state     <= IDLE;
               busy      <= 1'b0;
               req_ready <= 1'b1;
            end
            H_WR: begin
               state     <= IDLE;
               mem_write <= 1'b0;
               busy      <= 1'b0;
               req_ready <= 1'b1;
            end
            H_RD: begin
               state    <= H_CAP;
               mem_read <= 1'b0;
            end
            H_CAP: begin
               state     <= IDLE;
               rsp_rdata <= mem_data_out;
               rsp_valid <= 1'b1;
               busy      <= 1'b0;
               req_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
